ba_act_stream_unloader: RTL
===========================

Name: ba_act_stream_unloader

Overview:
- Downstream consumer of the bias-add core: once C = X + B is complete, walks the C matrix row-major through the core's 1-cycle-latency C read port.
- Optionally applies ReLU to each fp32 element.
- Emits elements on a valid/ready stream tagged with row/col/last, for the next EPU stage or the DMA writeback.
- An internal credit-controlled FIFO absorbs downstream backpressure, because the C read port cannot be stalled.

Parameters:
- M, 8, C rows
- N, 8, C columns
- DATA_W, 32, element width (fp32 bits)
- FIFO_DEPTH, 4, output FIFO entries; must be at least 2 and a power of 2
- ROW_W, (M<=1)?1:$clog2(M), row index width
- COL_W, (N<=1)?1:$clog2(N), column index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin unload; sampled only in IDLE
- relu_en  in  1  ReLU enable; latched on accepted start
- src_c_valid  in  1  C matrix complete (C_valid from the bias-add core)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the final beat is accepted
- c_rd_en  out  1  read request enable
- c_rd_re  out  1  read strobe; equals c_rd_en
- c_rd_row  out  ROW_W  read row
- c_rd_col  out  COL_W  read column
- c_rd_rdata  in  DATA_W  read data, valid when c_rd_rvalid
- c_rd_rvalid  in  1  read data valid, one cycle after the request
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  DATA_W  element after activation
- out_row  out  ROW_W  element row
- out_col  out  COL_W  element column
- out_last  out  1  high on element (M-1, N-1)

Behaviour:
- Reset values: busy=0, done=0, c_rd_en=c_rd_re=0, c_rd_row=c_rd_col=0, out_valid=0, out_last=0. FIFO emptied, inflight=0, counters=0, state=IDLE.
- Reset mid-run aborts immediately:
  - no done pulse;
  - FIFO contents discarded;
  - a c_rd_rvalid arriving in the cycle after reset deassertion is ignored (inflight was cleared).
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start && src_c_valid → latch relu_en; rd_row=rd_col=0; go to ISSUE. start with src_c_valid=0 is ignored (stay in IDLE, no outputs change). start is ignored in ISSUE and DRAIN.
  - ISSUE: issue = (fifo_count + inflight) < FIFO_DEPTH, where fifo_count is the registered occupancy and inflight is the registered flag "a read was issued in the previous cycle". c_rd_en = c_rd_re = issue, combinational. c_rd_row/c_rd_col are driven from the address counters. On issue:
    - col increments;
    - at col == N-1, col wraps to 0 and row increments;
    - the issue of (M-1, N-1) moves the FSM to DRAIN.
  - DRAIN: no reads. When the beat with out_last is accepted (out_valid && out_ready): done=1 for the next cycle, state → IDLE.
- Read return: c_rd_rvalid pushes {act(c_rd_rdata), row, col, last} into the FIFO. The tag is taken from a one-stage register of the issued address. The credit rule guarantees the push never overflows. An rvalid arriving while inflight=0 is ignored.
- Activation act(x), with relu_en=1:
  - NaN (exp=0xFF, mant≠0): pass through unchanged;
  - else if sign=1: output 0x00000000, which covers -0, negative denormals and -inf;
  - else: pass through.
  - With relu_en=0: identity.
- Stream interface:
  - out_valid = (fifo_count != 0); out_data/out_row/out_col/out_last come from the FIFO head.
  - Pop on out_valid && out_ready. Push and pop in the same cycle leave the count unchanged.
  - Head fields stay stable while out_valid && !out_ready.
- Latency: start accepted at edge E0 → first c_rd_re in cycle 1 → rvalid in cycle 2 → out_valid in cycle 3.
- Throughput: with out_ready held at 1, one beat per cycle; M*N beats total.
- done pulses exactly once per run, in the cycle after the last handshake; busy falls in that same cycle.
- Back-to-back runs: start may be accepted in the cycle done is high.
- Index arithmetic compares against the width-cast constants M-1 and N-1; there is no overflow beyond those bounds.

Test Plan:
- Full drain, M=N=8, C[r][c]=r*8+c as fp32, relu_en=0, out_ready=1:
  - 64 beats in row-major order, one per cycle;
  - first out_valid 3 cycles after the start edge;
  - out_last only on (7,7);
  - done pulses once, one cycle after the last beat.
- ReLU, relu_en=1, C values 0xBF800000, 0x80000000, 0x3F800000, 0x7FC00001, 0xFFC00000, 0xFF800000:
  - outputs 0x00000000, 0x00000000, 0x3F800000, 0x7FC00001, 0xFFC00000, 0x00000000.
- Backpressure, out_ready=0 for 12 cycles after start:
  - exactly FIFO_DEPTH (4) read strobes, then c_rd_re held at 0;
  - head data stable throughout;
  - after release, all 64 beats arrive with no loss or duplication.
- Random out_ready (50%):
  - the sequence matches the golden list;
  - the FIFO never overflows (checked by assertion).
- start with src_c_valid=0 → no reads, busy stays 0. start pulsed while busy → ignored, and the run still yields exactly 64 beats.
- rst asserted after beat 20:
  - next cycle: busy=0, out_valid=0, c_rd_re=0, no done pulse;
  - a new start then delivers all 64 beats beginning at (0,0).

Source files
------------

// File: rtl/ba_act_stream_unloader.sv
// Walks the completed C matrix row-major through a 1-cycle read port, applies optional ReLU,
// and streams tagged elements out through a credit-protected FIFO.
module ba_act_stream_unloader #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W      = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              relu_en,
  input  logic              src_c_valid,
  output logic              busy,
  output logic              done,
  output logic              c_rd_en,
  output logic              c_rd_re,
  output logic [ROW_W-1:0]  c_rd_row,
  output logic [COL_W-1:0]  c_rd_col,
  input  logic [DATA_W-1:0] c_rd_rdata,
  input  logic              c_rd_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + ROW_W + COL_W + 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic               relu_reg;
  logic [ROW_W-1:0]   rd_row_reg;
  logic [COL_W-1:0]   rd_col_reg;
  logic               inflight_reg;
  logic [ROW_W-1:0]   tag_row_reg;
  logic [COL_W-1:0]   tag_col_reg;
  logic               tag_last_reg;
  logic               done_reg;

  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               issue, last_addr, accept_start, push, pop;
  logic [CNT_W:0]     credit_sum;
  logic [DATA_W-1:0]  act_data;
  logic [ENT_W-1:0]   push_word, head_word;
  logic               head_last;

  // NaN keeps its payload even when negative; every other negative becomes +0.
  function automatic logic [DATA_W-1:0] act(input logic [DATA_W-1:0] x, input logic en);
    logic is_nan;
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    if (en && !is_nan && x[DATA_W-1])
      return '0;
    return x;
  endfunction

  assign last_addr    = (rd_row_reg == ROW_LAST) && (rd_col_reg == COL_LAST);
  assign accept_start = (state_reg == IDLE) && start && src_c_valid;
  // The read port cannot stall, so only issue when the FIFO has room for every outstanding read.
  assign credit_sum   = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg);
  assign issue        = (state_reg == ISSUE) && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));

  assign push      = c_rd_rvalid && inflight_reg;
  assign pop       = out_valid && out_ready;
  assign act_data  = act(c_rd_rdata, relu_reg);
  assign push_word = {act_data, tag_row_reg, tag_col_reg, tag_last_reg};
  assign head_word = fifo_mem[rd_ptr_reg];
  assign head_last = head_word[0];

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_start) state_next = ISSUE;
      ISSUE:   if (issue && last_addr) state_next = DRAIN;
      DRAIN:   if (pop && head_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != IDLE);
    done     = done_reg;
    c_rd_en  = issue;
    c_rd_re  = issue;
    c_rd_row = rd_row_reg;
    c_rd_col = rd_col_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      relu_reg     <= 1'b0;
      rd_row_reg   <= '0;
      rd_col_reg   <= '0;
      inflight_reg <= 1'b0;
      tag_row_reg  <= '0;
      tag_col_reg  <= '0;
      tag_last_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= (state_reg == DRAIN) && pop && head_last;
      inflight_reg <= issue;
      if (accept_start) begin
        relu_reg   <= relu_en;
        rd_row_reg <= '0;
        rd_col_reg <= '0;
      end else if (issue) begin
        tag_row_reg  <= rd_row_reg;
        tag_col_reg  <= rd_col_reg;
        tag_last_reg <= last_addr;
        if (rd_col_reg == COL_LAST) begin
          rd_col_reg <= '0;
          rd_row_reg <= (rd_row_reg == ROW_LAST) ? '0 : rd_row_reg + 1'b1;
        end else begin
          rd_col_reg <= rd_col_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= push_word;
  end

  assign out_valid = (count_reg != '0);
  assign out_data  = head_word[ENT_W-1 -: DATA_W];
  assign out_row   = head_word[COL_W+ROW_W -: ROW_W];
  assign out_col   = head_word[COL_W -: COL_W];
  // Gated so the flag is clean while the FIFO storage is still uninitialised.
  assign out_last  = out_valid && head_last;

endmodule
